// File: rtl/sfx_voice_mixer.sv
// Multi-voice sound-effect mixer: each sample tick walks every voice slot through
// the shared async SRAM, scales each sample by a shift and sums with saturation.

module sfx_voice_slot #(
    parameter int ADDR_W = 20,
    parameter int VOL_W  = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              trig,
    input  logic [ADDR_W-1:0] trig_addr,
    input  logic [ADDR_W-1:0] trig_len,
    input  logic [VOL_W-1:0]  trig_vol,
    input  logic              trig_loop,
    input  logic              stop,
    input  logic              adv,
    output logic              active,
    output logic [ADDR_W-1:0] addr,
    output logic [VOL_W-1:0]  vol
);
    logic [ADDR_W-1:0] start_r, len_r, pos_r, pos_inc;
    logic              loop_r;

    assign pos_inc = pos_r + 1'b1;
    assign addr    = start_r + pos_r;

    // Trigger beats stop, stop beats the per-frame position advance.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            start_r <= '0;
            len_r   <= '0;
            pos_r   <= '0;
            vol     <= '0;
            loop_r  <= 1'b0;
            active  <= 1'b0;
        end else if (trig) begin
            start_r <= trig_addr;
            len_r   <= trig_len;
            vol     <= trig_vol;
            loop_r  <= trig_loop;
            pos_r   <= '0;
            active  <= (trig_len != '0);
        end else if (stop) begin
            active  <= 1'b0;
        end else if (adv && active) begin
            if (pos_inc == len_r) begin
                pos_r  <= '0;
                active <= loop_r;
            end else begin
                pos_r  <= pos_inc;
            end
        end
    end
endmodule

module sfx_voice_mixer #(
    parameter int NUM_VOICES = 4,
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 16,
    parameter int VOL_W      = 2,
    parameter int VID_W      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_sample_tick,
    input  logic                     i_passthru,
    input  logic [ADDR_W-1:0]        i_time,
    input  logic                     i_trig,
    input  logic [VID_W-1:0]         i_trig_voice,
    input  logic [ADDR_W-1:0]        i_trig_addr,
    input  logic [ADDR_W-1:0]        i_trig_len,
    input  logic [VOL_W-1:0]         i_trig_vol,
    input  logic                     i_trig_loop,
    input  logic [NUM_VOICES-1:0]    i_stop,
    input  logic signed [DATA_W-1:0] i_sram_dq,
    output logic [ADDR_W-1:0]        o_sram_addr,
    output logic signed [DATA_W-1:0] o_sample,
    output logic                     o_sample_valid,
    output logic                     o_busy,
    output logic                     o_overrun,
    output logic [NUM_VOICES-1:0]    o_active
);
    localparam int ACC_W = DATA_W + VID_W + 1;
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic [VID_W-1:0] LAST_VID = VID_W'(NUM_VOICES - 1);

    typedef enum logic {IDLE, READ} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [ADDR_W-1:0] len;
        logic [VOL_W-1:0]  vol;
        logic              loop;
    } trig_req_t;

    state_t                          state_r, state_nxt;
    logic                            mode_r;
    logic [VID_W-1:0]                k_r, k_nxt;
    logic signed [ACC_W-1:0]         acc_r, acc_sum, contrib;
    logic signed [DATA_W-1:0]        shifted, sat_val;
    logic                            accept, last;
    logic [ADDR_W-1:0]               next_addr;
    trig_req_t                       trig_req;

    logic [NUM_VOICES-1:0]              voice_active, voice_adv, voice_trig;
    logic [NUM_VOICES-1:0][ADDR_W-1:0]  voice_addr;
    logic [NUM_VOICES-1:0][VOL_W-1:0]   voice_vol;

    assign trig_req = '{addr: i_trig_addr, len: i_trig_len, vol: i_trig_vol, loop: i_trig_loop};

    genvar v;
    generate
        for (v = 0; v < NUM_VOICES; v++) begin : g_voice
            assign voice_trig[v] = i_trig && (i_trig_voice == VID_W'(v));
            assign voice_adv[v]  = (state_r == READ) && !mode_r && (k_r == VID_W'(v));
            sfx_voice_slot #(.ADDR_W(ADDR_W), .VOL_W(VOL_W)) u_slot (
                .i_clk     (i_clk),
                .i_rst     (i_rst),
                .trig      (voice_trig[v]),
                .trig_addr (trig_req.addr),
                .trig_len  (trig_req.len),
                .trig_vol  (trig_req.vol),
                .trig_loop (trig_req.loop),
                .stop      (i_stop[v]),
                .adv       (voice_adv[v]),
                .active    (voice_active[v]),
                .addr      (voice_addr[v]),
                .vol       (voice_vol[v])
            );
        end
    endgenerate

    // A tick landing in the valid cycle is treated as busy and dropped.
    assign o_busy   = (state_r == READ) || o_sample_valid;
    assign accept   = i_sample_tick && (state_r == IDLE) && !o_sample_valid;
    assign last     = mode_r || (k_r == LAST_VID);
    assign o_active = voice_active;

    always_comb begin
        state_nxt = state_r;
        case (state_r)
            IDLE:    if (accept) state_nxt = READ;
            READ:    if (last)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        k_nxt     = k_r + 1'b1;
        next_addr = (k_r == LAST_VID) ? o_sram_addr : voice_addr[k_nxt];
        shifted   = i_sram_dq >>> voice_vol[k_r];
        contrib   = voice_active[k_r] ? {{(ACC_W-DATA_W){shifted[DATA_W-1]}}, shifted} : '0;
        acc_sum   = acc_r + contrib;
        if (acc_sum > SAT_MAX)      sat_val = SAT_MAX[DATA_W-1:0];
        else if (acc_sum < SAT_MIN) sat_val = SAT_MIN[DATA_W-1:0];
        else                        sat_val = acc_sum[DATA_W-1:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mode_r         <= 1'b0;
            k_r            <= '0;
            acc_r          <= '0;
            o_sram_addr    <= '0;
            o_sample       <= '0;
            o_sample_valid <= 1'b0;
            o_overrun      <= 1'b0;
        end else begin
            o_sample_valid <= 1'b0;
            o_overrun      <= i_sample_tick && o_busy;
            case (state_r)
                IDLE: begin
                    if (accept) begin
                        mode_r      <= i_passthru;
                        k_r         <= '0;
                        acc_r       <= '0;
                        o_sram_addr <= i_passthru ? i_time : voice_addr[0];
                    end
                end
                READ: begin
                    if (mode_r) begin
                        o_sample       <= i_sram_dq;
                        o_sample_valid <= 1'b1;
                    end else begin
                        acc_r       <= acc_sum;
                        k_r         <= k_nxt;
                        o_sram_addr <= next_addr;
                        if (last) begin
                            o_sample       <= sat_val;
                            o_sample_valid <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sfx_voice_mixer.sv
// Scoreboard bench for sfx_voice_mixer: stimulus pushes expected samples with their
// due cycle; a negedge monitor pops and compares on every o_sample_valid.

module tb_sfx_voice_mixer;
    localparam int NV = 4;
    localparam int AW = 20;
    localparam int DW = 16;
    localparam int VW = 2;
    localparam int IW = 2;

    logic          i_clk, i_rst, i_sample_tick, i_passthru, i_trig, i_trig_loop;
    logic [AW-1:0] i_time, i_trig_addr, i_trig_len, o_sram_addr;
    logic [IW-1:0] i_trig_voice;
    logic [VW-1:0] i_trig_vol;
    logic [NV-1:0] i_stop, o_active;
    logic [DW-1:0] i_sram_dq, o_sample;
    logic          o_sample_valid, o_busy, o_overrun;

    logic          sram_const_en;
    logic [DW-1:0] sram_const;

    assign i_sram_dq = sram_const_en ? sram_const : o_sram_addr[DW-1:0];

    sfx_voice_mixer #(.NUM_VOICES(NV), .ADDR_W(AW), .DATA_W(DW), .VOL_W(VW)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_sample_tick  (i_sample_tick),
        .i_passthru     (i_passthru),
        .i_time         (i_time),
        .i_trig         (i_trig),
        .i_trig_voice   (i_trig_voice),
        .i_trig_addr    (i_trig_addr),
        .i_trig_len     (i_trig_len),
        .i_trig_vol     (i_trig_vol),
        .i_trig_loop    (i_trig_loop),
        .i_stop         (i_stop),
        .i_sram_dq      (i_sram_dq),
        .o_sram_addr    (o_sram_addr),
        .o_sample       (o_sample),
        .o_sample_valid (o_sample_valid),
        .o_busy         (o_busy),
        .o_overrun      (o_overrun),
        .o_active       (o_active)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] smp;
        int            due;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(negedge i_clk) begin
        exp_t e;
        if (o_sample_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid: got sample=%0h expected no valid (cycle %0d)", o_sample, cyc);
            end else begin
                e = sb.pop_front();
                check("sample", o_sample, e.smp);
                check("valid_cycle", cyc, e.due);
            end
        end
    end

    task automatic drive(input logic t, input int v, input logic [AW-1:0] a, input logic [AW-1:0] l,
                         input logic [VW-1:0] vol, input logic lp, input logic [NV-1:0] stp);
        @(posedge i_clk); #1;
        i_trig = t; i_trig_voice = IW'(v); i_trig_addr = a; i_trig_len = l;
        i_trig_vol = vol; i_trig_loop = lp; i_stop = stp;
        @(posedge i_clk); #1;
        i_trig = 1'b0; i_stop = '0;
    endtask

    task automatic frame(input logic [DW-1:0] e, input logic pt, input logic [AW-1:0] t);
        int lat;
        lat = pt ? 2 : NV + 1;
        @(posedge i_clk); #1;
        sb.push_back('{smp: e, due: cyc + lat});
        i_sample_tick = 1'b1; i_passthru = pt; i_time = t;
        @(posedge i_clk); #1;
        i_sample_tick = 1'b0; i_passthru = 1'b0;
        if (pt) check("pt_sram_addr", o_sram_addr, t);
        check("busy_in_frame", o_busy, 1);
        repeat (NV + 2) @(posedge i_clk); #1;
        check("idle_after_frame", o_busy, 0);
    endtask

    initial begin
        i_rst = 1'b1; i_sample_tick = 0; i_passthru = 0; i_time = '0;
        i_trig = 0; i_trig_voice = '0; i_trig_addr = '0; i_trig_len = '0;
        i_trig_vol = '0; i_trig_loop = 0; i_stop = '0;
        sram_const_en = 0; sram_const = '0;
        repeat (3) @(posedge i_clk); #1;
        check("rst_sram_addr", o_sram_addr, 0);
        check("rst_sample", o_sample, 0);
        check("rst_valid", o_sample_valid, 0);
        check("rst_busy", o_busy, 0);
        check("rst_overrun", o_overrun, 0);
        check("rst_active", o_active, 0);
        i_rst = 1'b0;

        // One-shot effect, length 3
        drive(1, 0, 20'h100, 3, 0, 0, '0);
        check("oneshot_active", o_active, 4'b0001);
        frame(16'd256, 0, '0);
        frame(16'd257, 0, '0);
        check("oneshot_active_f2", o_active[0], 1);
        frame(16'd258, 0, '0);
        check("oneshot_active_end", o_active[0], 0);
        frame(16'd0, 0, '0);
        frame(16'd0, 0, '0);

        // Looping effect, length 2
        drive(1, 0, 20'h100, 2, 0, 1, '0);
        for (int i = 0; i < 4; i++) frame((i % 2) ? 16'd257 : 16'd256, 0, '0);
        check("loop_active", o_active[0], 1);

        // Volume shift, with v0 stopped in the same cycle
        drive(1, 1, 20'h100, 10, 2, 0, 4'b0001);
        check("vol_active", o_active, 4'b0010);
        frame(16'd64, 0, '0);
        drive(1, 1, 20'h100, 10, 3, 0, '0);
        sram_const_en = 1; sram_const = 16'hFFF8;
        frame(16'hFFFF, 0, '0);

        // Saturation with all four voices
        for (int v = 0; v < NV; v++) drive(1, v, 20'h0, 10, 0, 0, '0);
        check("sat_active", o_active, 4'b1111);
        sram_const = 16'h7000; frame(16'h7FFF, 0, '0);
        sram_const = 16'h1000; frame(16'h4000, 0, '0);
        sram_const = 16'h9000; frame(16'h8000, 0, '0);

        // Passthrough leaves voice positions alone
        sram_const_en = 0;
        drive(1, 0, 20'h100, 10, 0, 0, 4'b1110);
        check("pt_active", o_active, 4'b0001);
        frame(16'd256, 0, '0);
        frame(16'h1234, 1, 20'h1234);
        frame(16'd257, 0, '0);

        // Overrun: tick 2 cycles in, then a tick in the valid cycle
        @(posedge i_clk); #1;
        sb.push_back('{smp: 16'd258, due: cyc + NV + 1});
        i_sample_tick = 1;
        @(posedge i_clk); #1; i_sample_tick = 0;
        @(posedge i_clk); #1; i_sample_tick = 1;
        @(posedge i_clk); #1; i_sample_tick = 0;
        check("overrun_busy", o_overrun, 1);
        @(posedge i_clk); #1;
        check("overrun_clear", o_overrun, 0);
        @(posedge i_clk); #1;
        check("valid_cycle_seen", o_sample_valid, 1);
        i_sample_tick = 1;
        @(posedge i_clk); #1; i_sample_tick = 0;
        check("overrun_valid_cycle", o_overrun, 1);
        check("tick_in_valid_dropped", o_busy, 0);
        repeat (8) @(posedge i_clk); #1;

        // Reset one cycle after a tick aborts the frame
        i_sample_tick = 1;
        @(posedge i_clk); #1; i_sample_tick = 0; i_rst = 1;
        @(posedge i_clk); #1; i_rst = 0;
        check("midrst_sram_addr", o_sram_addr, 0);
        check("midrst_sample", o_sample, 0);
        check("midrst_busy", o_busy, 0);
        check("midrst_active", o_active, 0);
        repeat (8) @(posedge i_clk); #1;

        // Trigger and stop on the same voice: trigger wins with pos=0
        drive(1, 0, 20'h200, 5, 0, 0, 4'b0001);
        check("collide_active", o_active, 4'b0001);
        frame(16'd512, 0, '0);

        repeat (4) @(posedge i_clk); #1;
        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sfx_voice_mixer.md
Name: sfx_voice_mixer

Overview:
- N-voice successor to the single-event sound-effect player.
- Holds up to NUM_VOICES concurrently playing effects, each with its own start address, length, volume shift and loop flag.
- On each audio sample tick it time-multiplexes the shared asynchronous SRAM across the voices, then sums the volume-scaled samples with saturation.
- A passthrough mode plays raw SRAM contents at an external time index, for playback of the recorded track. Sits between the button/event decoder and the audio DAC interface.

Parameters:
- NUM_VOICES, 4, number of voice slots (≥1).
- ADDR_W, 20, SRAM address / time width.
- DATA_W, 16, signed sample width.
- VOL_W, 2, volume shift-amount width.
- VID_W, $clog2(NUM_VOICES) (min 1), voice index width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-high.
- i_sample_tick  in  1  one-cycle pulse; starts one mix frame.
- i_passthru  in  1  1 = passthrough mode (sampled at frame start).
- i_time  in  ADDR_W  SRAM address used in passthrough.
- i_trig  in  1  start/restart a voice.
- i_trig_voice  in  VID_W  target slot.
- i_trig_addr  in  ADDR_W  effect start address.
- i_trig_len  in  ADDR_W  effect length in samples.
- i_trig_vol  in  VOL_W  arithmetic right-shift applied to samples.
- i_trig_loop  in  1  1 = wrap to start at end.
- i_stop  in  NUM_VOICES  per-voice stop mask.
- i_sram_dq  in  DATA_W  signed SRAM read data (async, valid while o_sram_addr is stable).
- o_sram_addr  out  ADDR_W  registered SRAM address.
- o_sample  out  DATA_W  signed mixed sample, held between frames.
- o_sample_valid  out  1  one-cycle pulse when o_sample updates.
- o_busy  out  1  frame in progress.
- o_overrun  out  1  one-cycle pulse when a tick is dropped.
- o_active  out  NUM_VOICES  per-voice playing flags.

Behaviour:
- Reset: state IDLE; all voices inactive with pos=0. o_sram_addr=0, o_sample=0, o_sample_valid=0, o_busy=0, o_overrun=0, o_active=0. A reset mid-frame aborts the frame and no valid pulse is issued.
- FSM states:
  - IDLE → READ on i_sample_tick. At that edge, latch i_passthru into mode_r, set voice index k=0, and load o_sram_addr with the first address.
  - READ: one cycle per voice. At each edge, capture i_sram_dq for the current address, accumulate, and load o_sram_addr with the next voice's address.
  - After the last voice (normal mode) or the single read (passthrough), return to IDLE. At that same edge, register o_sample and pulse o_sample_valid.
- Latency: tick in cycle 0 → o_sample_valid in cycle NUM_VOICES+1 in normal mode, cycle 2 in passthrough. o_busy is high from cycle 1 until the valid cycle inclusive.
- Voice address: start + pos (ADDR_W, wraps modulo 2^ADDR_W).
- Contribution: (i_sram_dq >>> vol) if the voice is active, else 0. Inactive voices still consume their READ cycle, so frame length is fixed.
- Accumulator: signed, DATA_W+VID_W+1 bits, cleared at frame start. Final value saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Position advance: occurs at the voice's READ edge, active voices only.
  - If pos+1 == len: loop=1 sets pos=0; loop=0 sets active=0 and pos=0.
  - Otherwise pos+1.
- Passthrough: o_sram_addr = i_time. Output = i_sram_dq unshifted, no saturation needed. Voice state is frozen, with no position advance.
- Trigger handling:
  - i_trig writes addr/len/vol/loop, sets pos=0 and active=1 at the next edge, in any state.
  - i_trig_len=0 → slot is written inactive.
  - If the trigger hits the voice in its own READ cycle, the sample already addressed is still used; the trigger wins over the position advance.
- i_stop: clears active for masked voices at the edge. If i_trig and i_stop hit the same voice in the same cycle, the trigger wins.
- A tick while o_busy=1 is dropped and o_overrun pulses for one cycle. A tick in the valid cycle is also dropped.
- o_active reflects the registered active flags.

Test Plan:
- SRAM model returns dq=addr[15:0]. Trigger v0 addr=0x100 len=3 vol=0 loop=0, then 5 ticks → o_sample = 256, 257, 258, 0, 0. o_active[0] falls after the 3rd frame. Valid pulse occurs 5 cycles after each tick (NUM_VOICES=4).
- Same setup with loop=1, len=2 → 256, 257, 256, 257 repeating; o_active[0] stays 1.
- Volume: v1 addr=0x100 vol=2 → 64. With vol=3 and the model returning -8 → -1 (arithmetic shift).
- Saturation: 4 voices, model returns 0x7000 → 32767. Model returns -28672 (0x9000) → -32768.
- Passthrough: i_passthru=1, i_time=0x1234 → o_sram_addr=0x1234, o_sample=0x1234, valid 2 cycles after tick; active voice pos unchanged.
- Overrun/reset/collision:
  - A second tick 2 cycles after the first → o_overrun pulses and only one valid pulse occurs.
  - i_rst in the cycle after a tick → no valid pulse and all outputs 0.
  - i_trig and i_stop on v0 in the same cycle → v0 active, pos=0.
